// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment driver: glyph table,
// segment bit positions and the scan divider helper.
package seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}; entry 15 listed first.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b1110001,  // F
    7'b1111001,  // E
    7'b1011110,  // d
    7'b0111001,  // C
    7'b1111100,  // b
    7'b1110111,  // A
    7'b1101111,  // 9
    7'b1111111,  // 8
    7'b0000111,  // 7
    7'b1111101,  // 6
    7'b1101101,  // 5
    7'b1100110,  // 4
    7'b1001111,  // 3
    7'b1011011,  // 2
    7'b0000110,  // 1
    7'b0111111   // 0
  };

  // Clocks per digit dwell; returns 0 for an unusable ratio so the caller can reject it.
  function automatic int calc_div(input int clk_freq, input int scan_freq);
    if (scan_freq <= 0) return 0;
    if (clk_freq / scan_freq < 2) return 0;
    return clk_freq / scan_freq;
  endfunction

endpackage

// File: rtl/seg_hex_lut.sv
// Combinational hex nibble to active-high 7-segment glyph lookup.
module seg_hex_lut
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  assign glyph = SEG_TABLE[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// N-digit time-multiplexed 7-segment driver with frame-coherent snapshot,
// per-digit blanking, leading-zero suppression and selectable polarity.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 6,
  parameter int CLK_FREQ       = 50_000_000,
  parameter int SCAN_FREQ      = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_blank,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   sel_out,
  output logic                    frame_done
);

  localparam int DIV   = calc_div(CLK_FREQ, SCAN_FREQ);
  localparam int PS_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0]            SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = SEL_ACTIVE_LOW ? '1 : '0;

  if (DIV < 2) begin : g_bad_div
    $error("seg_scan_driver: CLK_FREQ/SCAN_FREQ must be at least 2");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("seg_scan_driver: NUM_DIGITS must be within 1..8");
  end

  logic [PS_W-1:0]         prescaler;
  logic [IDX_W-1:0]        idx;
  logic                    load_pending;
  logic                    tick;
  logic                    wrap;
  logic                    load;

  logic [4*NUM_DIGITS-1:0] snap_data;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic [NUM_DIGITS-1:0]   snap_mask;
  logic                    snap_lz;

  logic [4*NUM_DIGITS-1:0] view_data;
  logic [NUM_DIGITS-1:0]   view_dp;
  logic [NUM_DIGITS-1:0]   view_mask;
  logic                    view_lz;

  logic [NUM_DIGITS-1:0]   lead_zero;
  logic [3:0]              cur_nibble;
  logic [6:0]              cur_glyph;
  logic [7:0]              seg_next;
  logic [NUM_DIGITS-1:0]   sel_next;

  assign tick = (prescaler == PS_W'(DIV - 1));
  assign wrap = tick && (idx == IDX_W'(NUM_DIGITS - 1));
  assign load = en && (load_pending || wrap);

  // The first displayed digit after a restart must come from the live inputs,
  // because the shadow copy is only being captured on that same edge.
  assign view_data = load_pending ? data_in    : snap_data;
  assign view_dp   = load_pending ? dp_in      : snap_dp;
  assign view_mask = load_pending ? blank_mask : snap_mask;
  assign view_lz   = load_pending ? lz_blank   : snap_lz;

  // NOTE: shadow registers carry no reset; load_pending forces a fresh capture before any use.
  always_ff @(posedge clk) begin
    if (load) begin
      snap_data <= data_in;
      snap_dp   <= dp_in;
      snap_mask <= blank_mask;
      snap_lz   <= lz_blank;
    end
  end

  always_comb begin : lz_scan
    logic zero_run;
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run     = zero_run && (view_data[4*k +: 4] == 4'h0);
      lead_zero[k] = zero_run && (k != 0);
    end
  end

  assign cur_nibble = view_data[4*idx +: 4];

  seg_hex_lut u_lut (
    .nibble (cur_nibble),
    .glyph  (cur_glyph)
  );

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    seg_next              = '0;
    seg_next[SEG_G:SEG_A] = cur_glyph;
    seg_next[SEG_DP]      = view_dp[idx];
    if (view_mask[idx]) begin
      seg_next = '0;
    end else if (view_lz && lead_zero[idx]) begin
      seg_next[SEG_G:SEG_A] = '0;
    end
  end

  assign sel_next = NUM_DIGITS'(1) << idx;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      prescaler    <= '0;
      idx          <= '0;
      load_pending <= 1'b1;
      frame_done   <= 1'b0;
      seg_out      <= SEG_OFF;
      sel_out      <= SEL_OFF;
    end else begin
      prescaler    <= tick ? '0 : prescaler + PS_W'(1);
      if (tick) begin
        idx <= wrap ? '0 : idx + IDX_W'(1);
      end
      frame_done   <= wrap;
      load_pending <= 1'b0;
      seg_out      <= seg_next ^ SEG_OFF;
      sel_out      <= sel_next ^ SEL_OFF;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: 4 digits, 4 clocks per digit dwell,
// one active-low instance and one active-high instance sharing the stimulus.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_mask;
  logic        lz_blank;
  logic [7:0]  seg_out, seg_out_hi;
  logic [3:0]  sel_out, sel_out_hi;
  logic        frame_done, frame_done_hi;

  int n_checks = 0;
  int n_fail   = 0;

  // Active-low glyphs (dp off) for the frames used below, listed digit 0 first.
  localparam logic [7:0] FRAME_1234 [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
  localparam logic [7:0] FRAME_ABCD [4] = '{8'hA1, 8'hC6, 8'h83, 8'h88};
  localparam logic [7:0] FRAME_0005 [4] = '{8'h92, 8'hFF, 8'hFF, 8'hFF};
  localparam logic [7:0] FRAME_ZDP  [4] = '{8'hC0, 8'hFF, 8'h7F, 8'hFF};
  localparam logic [7:0] FRAME_MASK [4] = '{8'h99, 8'hFF, 8'hA4, 8'hF9};

  always #5 clk = ~clk;

  seg_scan_driver #(
    .NUM_DIGITS(4), .CLK_FREQ(8), .SCAN_FREQ(2),
    .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .dp_in(dp_in),
    .blank_mask(blank_mask), .lz_blank(lz_blank),
    .seg_out(seg_out), .sel_out(sel_out), .frame_done(frame_done)
  );

  seg_scan_driver #(
    .NUM_DIGITS(4), .CLK_FREQ(8), .SCAN_FREQ(2),
    .SEG_ACTIVE_LOW(1'b0), .SEL_ACTIVE_LOW(1'b0)
  ) dut_hi (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .dp_in(dp_in),
    .blank_mask(blank_mask), .lz_blank(lz_blank),
    .seg_out(seg_out_hi), .sel_out(sel_out_hi), .frame_done(frame_done_hi)
  );

  task automatic restart();
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; data_in = 16'h1234;
    dp_in = '0; blank_mask = '0; lz_blank = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (seg_out !== 8'hFF) begin n_fail++; $display("FAIL reset_seg: got %h want ff", seg_out); end
    n_checks++;
    if (sel_out !== 4'hF) begin n_fail++; $display("FAIL reset_sel: got %b want 1111", sel_out); end
    n_checks++;
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    n_checks++;
    if (seg_out_hi !== 8'h00) begin n_fail++; $display("FAIL reset_seg_hi: got %h want 00", seg_out_hi); end
    n_checks++;
    if (sel_out_hi !== 4'h0) begin n_fail++; $display("FAIL reset_sel_hi: got %b want 0000", sel_out_hi); end
    rst = 1'b0;
  endtask

  // Two frames: data changes at cycle 6 must only show from the second frame on.
  task automatic test_scan_snapshot();
    for (int c = 1; c <= 32; c++) begin
      int d;
      logic [7:0] exp_seg;
      logic [3:0] exp_sel;
      @(negedge clk);
      d       = ((c - 1) / 4) % 4;
      exp_seg = (c <= 16) ? FRAME_1234[d] : FRAME_ABCD[d];
      exp_sel = ~(4'b0001 << d);
      n_checks++;
      if (seg_out !== exp_seg) begin n_fail++; $display("FAIL scan_seg c=%0d: got %h want %h", c, seg_out, exp_seg); end
      n_checks++;
      if (sel_out !== exp_sel) begin n_fail++; $display("FAIL scan_sel c=%0d: got %b want %b", c, sel_out, exp_sel); end
      n_checks++;
      if (frame_done !== (c % 16 == 0)) begin
        n_fail++; $display("FAIL scan_frame_done c=%0d: got %b want %b", c, frame_done, (c % 16 == 0));
      end
      if (c == 6) data_in = 16'hABCD;
    end
  endtask

  task automatic run_frame(input string name, input logic [7:0] exp_frame [4]);
    for (int c = 1; c <= 16; c++) begin
      int d;
      logic [3:0] exp_sel;
      @(negedge clk);
      d       = (c - 1) / 4;
      exp_sel = ~(4'b0001 << d);
      n_checks++;
      if (seg_out !== exp_frame[d]) begin
        n_fail++; $display("FAIL %s_seg c=%0d: got %h want %h", name, c, seg_out, exp_frame[d]);
      end
      n_checks++;
      if (sel_out !== exp_sel) begin
        n_fail++; $display("FAIL %s_sel c=%0d: got %b want %b", name, c, sel_out, exp_sel);
      end
    end
  endtask

  task automatic test_lz_suppress();
    data_in = 16'h0005; dp_in = '0; blank_mask = '0; lz_blank = 1'b1;
    restart();
    run_frame("lz_0005", FRAME_0005);
  endtask

  task automatic test_lz_zero_dp();
    data_in = 16'h0000; dp_in = 4'b0100; blank_mask = '0; lz_blank = 1'b1;
    restart();
    run_frame("lz_zero_dp", FRAME_ZDP);
  endtask

  task automatic test_blank_mask();
    data_in = 16'h1234; dp_in = 4'b0010; blank_mask = 4'b0010; lz_blank = 1'b0;
    restart();
    run_frame("blank_mask", FRAME_MASK);
  endtask

  task automatic test_en_drop_and_reset();
    data_in = 16'h1234; dp_in = '0; blank_mask = '0; lz_blank = 1'b0;
    restart();
    repeat (9) @(negedge clk);
    n_checks++;
    if (sel_out !== 4'b1011) begin n_fail++; $display("FAIL drop_pre_sel: got %b want 1011", sel_out); end
    en = 1'b0;
    @(negedge clk);
    n_checks++;
    if (seg_out !== 8'hFF) begin n_fail++; $display("FAIL drop_seg: got %h want ff", seg_out); end
    n_checks++;
    if (sel_out !== 4'hF) begin n_fail++; $display("FAIL drop_sel: got %b want 1111", sel_out); end
    n_checks++;
    if (sel_out_hi !== 4'h0) begin n_fail++; $display("FAIL drop_sel_hi: got %b want 0000", sel_out_hi); end
    data_in = 16'h8765;
    en = 1'b1;
    @(negedge clk);
    n_checks++;
    if (seg_out !== 8'h92) begin n_fail++; $display("FAIL resume_seg: got %h want 92", seg_out); end
    n_checks++;
    if (sel_out !== 4'b1110) begin n_fail++; $display("FAIL resume_sel: got %b want 1110", sel_out); end
    repeat (4) @(negedge clk);
    n_checks++;
    if (seg_out !== 8'h82) begin n_fail++; $display("FAIL resume_digit1_seg: got %h want 82", seg_out); end
    n_checks++;
    if (sel_out !== 4'b1101) begin n_fail++; $display("FAIL resume_digit1_sel: got %b want 1101", sel_out); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (seg_out !== 8'hFF) begin n_fail++; $display("FAIL midreset_seg: got %h want ff", seg_out); end
    n_checks++;
    if (sel_out !== 4'hF) begin n_fail++; $display("FAIL midreset_sel: got %b want 1111", sel_out); end
    rst = 1'b0;
  endtask

  task automatic test_active_high();
    data_in = 16'h0008; dp_in = '0; blank_mask = '0; lz_blank = 1'b0;
    restart();
    @(negedge clk);
    n_checks++;
    if (seg_out_hi !== 8'h7F) begin n_fail++; $display("FAIL hi_seg: got %h want 7f", seg_out_hi); end
    n_checks++;
    if (sel_out_hi !== 4'b0001) begin n_fail++; $display("FAIL hi_sel: got %b want 0001", sel_out_hi); end
    n_checks++;
    if (seg_out !== 8'h80) begin n_fail++; $display("FAIL lo_seg_8: got %h want 80", seg_out); end
    n_checks++;
    if (sel_out !== 4'b1110) begin n_fail++; $display("FAIL lo_sel_8: got %b want 1110", sel_out); end
  endtask

  initial begin
    test_reset();
    test_scan_snapshot();
    test_lz_suppress();
    test_lz_zero_dp();
    test_blank_mask();
    test_en_drop_and_reset();
    test_active_high();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
